// File: rtl/l2_arbiter_pkg.sv
// Shared types and constants for the L2 port arbiter.
package l2_arbiter_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    // Which L1 owns the current (or last) L2 transaction
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // The L2 is always accessed a full line at a time
    localparam logic [3:0] L2_FULL_BE = 4'hF;

endpackage

// File: rtl/l2_arb_select.sv
// Combinational picker between the I-cache and D-cache miss requests.
// With L2_ARB_ROUND_ROBIN_EN defined, a tie goes to the side that did not win
// the previous transaction; otherwise the D-cache always wins a tie.
module l2_arb_select
    import l2_arbiter_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
`ifdef L2_ARB_ROUND_ROBIN_EN
    input  grant_t last_grant,
`endif
    output grant_t grant,
    output logic   valid
);

    // Pick the winner; a lone request always wins, ties are resolved below
    always_comb begin
        valid = i_req | d_req;
        grant = GRANT_D;
        if (i_req && !d_req) begin
            grant = GRANT_I;
        end else if (i_req && d_req) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
            grant = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
`else
            grant = GRANT_D;
`endif
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 port between the L1 I-cache and L1 D-cache.
// One transaction at a time: the winner's address/data/write flag are latched
// in IDLE, presented to the L2 during SERVE_*, and the L2 completion pulse is
// passed straight through to the granted requester only.
// Optional: define L2_ARB_ROUND_ROBIN_EN for alternating tie resolution.
module l2_arbiter
    import l2_arbiter_pkg::*;
#(
    parameter int line_width = 256,
    parameter int addr_width = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_read,
    input  logic [addr_width-1:0] i_address,
    output logic [line_width-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [addr_width-1:0] d_address,
    input  logic [line_width-1:0] d_wdata,
    output logic [line_width-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  l2_read,
    output logic                  l2_write,
    output logic [addr_width-1:0] l2_address,
    output logic [line_width-1:0] l2_wdata,
    output logic [3:0]            l2_byte_enable,
    input  logic [line_width-1:0] l2_rdata,
    input  logic                  l2_resp
);

    arb_state_t            state_q, state_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [line_width-1:0] wdata_q, wdata_d;
    logic                  is_write_q, is_write_d;
    grant_t                sel_grant;
    logic                  sel_valid;
    logic                  d_req;

`ifdef L2_ARB_ROUND_ROBIN_EN
    grant_t                last_grant_q, last_grant_d;
`endif

    // Read and write together from the D side counts as a write-back
    assign d_req = d_read | d_write;

    l2_arb_select u_select (
        .i_req      (i_read),
        .d_req      (d_req),
`ifdef L2_ARB_ROUND_ROBIN_EN
        .last_grant (last_grant_q),
`endif
        .grant      (sel_grant),
        .valid      (sel_valid)
    );

    // Next-state: latch the winner in IDLE, return to IDLE on L2 completion
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
`ifdef L2_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    wdata_d = d_wdata;
                    if (sel_grant == GRANT_D) begin
                        addr_d     = d_address;
                        is_write_d = d_write;
                        state_d    = SERVE_D;
                    end else begin
                        addr_d     = i_address;
                        is_write_d = 1'b0;
                        state_d    = SERVE_I;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2_resp) begin
                    state_d = IDLE;
`ifdef L2_ARB_ROUND_ROBIN_EN
                    last_grant_d = (state_q == SERVE_D) ? GRANT_D : GRANT_I;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and transaction latches; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
`ifdef L2_ARB_ROUND_ROBIN_EN
            last_grant_q <= GRANT_I;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
`ifdef L2_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // L2 requests come only from flops; responses pass through to the owner
    always_comb begin
        l2_read  = (state_q != IDLE) && !is_write_q;
        l2_write = (state_q != IDLE) &&  is_write_q;
        i_resp   = (state_q == SERVE_I) && l2_resp;
        d_resp   = (state_q == SERVE_D) && l2_resp;
    end

    assign l2_address     = addr_q;
    assign l2_wdata       = wdata_q;
    assign l2_byte_enable = L2_FULL_BE;
    assign i_rdata        = l2_rdata;
    assign d_rdata        = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: expected transactions are queued when the
// L1 requests are driven and checked when the arbiter presents them to the L2
// and returns the response. Honours L2_ARB_ROUND_ROBIN_EN for tie ordering.
module tb_l2_arbiter;
    import l2_arbiter_pkg::*;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk;
    logic          reset;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          l2_read;
    logic          l2_write;
    logic [AW-1:0] l2_address;
    logic [LW-1:0] l2_wdata;
    logic [3:0]    l2_byte_enable;
    logic [LW-1:0] l2_rdata;
    logic          l2_resp;

    l2_arbiter #(.line_width(LW), .addr_width(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_read         (i_read),
        .i_address      (i_address),
        .i_rdata        (i_rdata),
        .i_resp         (i_resp),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_address      (d_address),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_resp         (d_resp),
        .l2_read        (l2_read),
        .l2_write       (l2_write),
        .l2_address     (l2_address),
        .l2_wdata       (l2_wdata),
        .l2_byte_enable (l2_byte_enable),
        .l2_rdata       (l2_rdata),
        .l2_resp        (l2_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        grant_t        side;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } exp_t;

    exp_t   sb_q[$];
    int     chk_cnt  = 0;
    int     pass_cnt = 0;
    grant_t model_last;

    localparam logic [LW-1:0] PAT_A = {8{32'hA5A5_1111}};
    localparam logic [LW-1:0] PAT_B = {8{32'hB00B_2222}};
    localparam logic [LW-1:0] PAT_C = {8{32'h3C3C_C3C3}};
    localparam logic [LW-1:0] PAT_D = {4{64'hDEAD_BEEF_0123_4567}};

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push_txn(input grant_t side, input logic wr, input logic [AW-1:0] addr,
                            input logic [LW-1:0] wdata);
        exp_t e;
        e.side = side; e.wr = wr; e.addr = addr; e.wdata = wdata;
        sb_q.push_back(e);
    endtask

    function automatic grant_t tie_winner();
`ifdef L2_ARB_ROUND_ROBIN_EN
        return (model_last == GRANT_D) ? GRANT_I : GRANT_D;
`else
        return GRANT_D;
`endif
    endfunction

    // Wait for the arbiter's L2 request, check it against the scoreboard head,
    // answer after lat cycles and check the steered response.
    task automatic serve(input int lat, input logic [LW-1:0] rdata, input bit poke_addr);
        int   n;
        exp_t e;
        n = 0;
        while (!(l2_read || l2_write) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        check("req_latency", n, 1);
        if (n >= 20) return;
        check("l2_read", l2_read, !e.wr);
        check("l2_write", l2_write, e.wr);
        check("l2_address", l2_address, e.addr);
        if (e.wr) check("l2_wdata", l2_wdata, e.wdata);
        check("l2_byte_enable", l2_byte_enable, 4'hF);
        for (int k = 1; k < lat; k++) begin
            if (poke_addr) begin
                d_address = ~d_address;
                i_address = ~i_address;
            end
            #1;
            check("early_resp", {i_resp, d_resp}, 2'b00);
            @(negedge clk);
        end
        check("addr_hold", l2_address, e.addr);
        l2_rdata = rdata;
        l2_resp  = 1'b1;
        #1;
        check("i_resp", i_resp, e.side == GRANT_I);
        check("d_resp", d_resp, e.side == GRANT_D);
        if (e.side == GRANT_I) check("i_rdata", i_rdata, rdata);
        else                   check("d_rdata", d_rdata, rdata);
        @(negedge clk);
        l2_resp = 1'b0;
        if (e.side == GRANT_I) i_read = 1'b0;
        else begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        #1;
        check("resp_pulse", {i_resp, d_resp}, 2'b00);
        check("idle_gap", {l2_read, l2_write}, 2'b00);
        model_last = e.side;
        $display("txn %s %s addr=%h lat=%0d", (e.side == GRANT_I) ? "I" : "D",
                 e.wr ? "WR" : "RD", e.addr, lat);
    endtask

    // Both L1s request at once; expected order comes from the tie model
    task automatic tie_round();
        grant_t w;
        i_read = 1'b1; i_address = 32'h0000_1000;
        d_read = 1'b1; d_address = 32'h0000_2000;
        w = tie_winner();
        if (w == GRANT_D) begin
            push_txn(GRANT_D, 1'b0, 32'h0000_2000, '0);
            push_txn(GRANT_I, 1'b0, 32'h0000_1000, '0);
        end else begin
            push_txn(GRANT_I, 1'b0, 32'h0000_1000, '0);
            push_txn(GRANT_D, 1'b0, 32'h0000_2000, '0);
        end
        serve(2, PAT_A, 1'b0);
        serve(2, PAT_B, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        l2_rdata = '0; l2_resp = 1'b0;
        model_last = GRANT_I;
        repeat (2) @(negedge clk);
        check("rst_l2_req", {l2_read, l2_write}, 2'b00);
        check("rst_resp", {i_resp, d_resp}, 2'b00);
        check("rst_l2_address", l2_address, 32'h0);
        reset = 1'b0;

        // I-only line read
        i_read = 1'b1; i_address = 32'h0000_1000;
        push_txn(GRANT_I, 1'b0, 32'h0000_1000, '0);
        serve(3, PAT_A, 1'b0);

        // D write-back
        d_write = 1'b1; d_address = 32'h8000_0040; d_wdata = PAT_B;
        push_txn(GRANT_D, 1'b1, 32'h8000_0040, PAT_B);
        serve(2, PAT_C, 1'b0);

        // Read and write together is a write; single-cycle L2 latency
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_3000; d_wdata = PAT_C;
        push_txn(GRANT_D, 1'b1, 32'h0000_3000, PAT_C);
        serve(1, PAT_D, 1'b0);

        // Reset in SERVE_D aborts with no response pulse
        d_read = 1'b1; d_address = 32'h0000_4000;
        @(negedge clk);
        check("abort_l2_read_before", l2_read, 1'b1);
        #2;
        reset = 1'b1; l2_resp = 1'b1;
        #1;
        check("abort_l2_read", l2_read, 1'b0);
        check("abort_d_resp", d_resp, 1'b0);
        check("abort_state", dut.state_q, IDLE);
        @(negedge clk);
        reset = 1'b0; l2_resp = 1'b0; d_read = 1'b0;
        model_last = GRANT_I;

        // Fresh D read with the address bus changing mid-transaction
        d_read = 1'b1; d_address = 32'h0000_5000;
        push_txn(GRANT_D, 1'b0, 32'h0000_5000, '0);
        serve(4, PAT_D, 1'b1);

        // Clean reset, then two back-to-back tie rounds
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_last = GRANT_I;
        tie_round();
        tie_round();

        // D-only transaction, then a tie that round-robin hands to I
        d_read = 1'b1; d_address = 32'h0000_6000;
        push_txn(GRANT_D, 1'b0, 32'h0000_6000, '0);
        serve(2, PAT_C, 1'b0);
        tie_round();

        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Shares the single L2 cache port between the L1 instruction cache and the L1 data cache. Each L1 sends its line-miss read or write-back here.
- Sequences one transaction at a time into the L2. It latches the granted request and steers the L2 response back to the granted requester only.
- Sits between the two L1 miss ports and the L2 cache.

Parameters:
- line_width, 256: width of a cache line in bits (i/d/l2 data buses).
- addr_width, 32: address width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- i_read  input  1  I-cache line read request; held until i_resp.
- i_address  input  addr_width  I-cache line address.
- i_rdata  output  line_width  line returned to I-cache.
- i_resp  output  1  one-cycle completion pulse to I-cache.
- d_read  input  1  D-cache line read request; held until d_resp.
- d_write  input  1  D-cache write-back request; held until d_resp.
- d_address  input  addr_width  D-cache line address.
- d_wdata  input  line_width  write-back line.
- d_rdata  output  line_width  line returned to D-cache.
- d_resp  output  1  one-cycle completion pulse to D-cache.
- l2_read  output  1  read request to L2.
- l2_write  output  1  write request to L2.
- l2_address  output  addr_width  latched address to L2; also drives the L2 next-address input.
- l2_wdata  output  line_width  latched write-back data.
- l2_byte_enable  output  4  constant 4'hF.
- l2_rdata  input  line_width  L2 read data.
- l2_resp  input  1  L2 completion pulse.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; addr_q, wdata_q, is_write_q and last_grant cleared.
  - All request and response outputs are 0; l2_address=0.
  - Asserting reset mid-transaction aborts it immediately with no response pulse. The L2 is reset on the same signal.
- States:
  - IDLE: no L2 request. Sample i_read, d_read|d_write.
    - If any request is present, latch the winner's address, d_wdata and write flag, then go to SERVE_I or SERVE_D.
    - If no request is present, stay in IDLE.
  - SERVE_I / SERVE_D: l2_read=!is_write_q, l2_write=is_write_q, l2_address=addr_q, l2_wdata=wdata_q.
    - When l2_resp=1: pulse i_resp or d_resp in that same cycle (combinational pass-through), update last_grant, return to IDLE.
- Data steering: i_rdata and d_rdata are both wired to l2_rdata. Only the granted side's resp is pulsed.
- Latency:
  - Request seen in cycle 0 gives L2 request asserted in cycle 1.
  - Response to the requester is in the same cycle as l2_resp.
  - There is at least one IDLE cycle between transactions. This guarantees the L1 has dropped its request before resampling.
- Arbitration (default): fixed priority, D-cache wins a simultaneous request. The I-cache can starve under continuous D traffic; this is accepted.
- Illegal inputs:
  - d_read and d_write both high is treated as a write.
  - A request dropped before its resp does not abort the transaction. The L2 access completes and the resp pulse is still issued.
- Inputs on the non-granted side are ignored during SERVE. Their request stays pending and is arbitrated in the next IDLE.

Optional Feature:
- Macro L2_ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request, grant the side that did not win last (last_grant flop). The first tie after reset goes to D.
- Undefined: fixed D priority. The last_grant flop is not built.

Decomposition:
- Shared package: enum arb_state_t {IDLE, SERVE_I, SERVE_D}; enum grant_t {GRANT_I, GRANT_D}; constant L2_FULL_BE=4'hF.
- One natural sub-module: l2_arb_select, a combinational priority/round-robin picker taking the two requests and last_grant and producing grant and valid. The FSM and latches stay in l2_arbiter.

Test Plan:
- I-only read: i_read=1, i_address=0x0000_1000, l2_resp after 3 cycles with rdata=pattern A → l2_read=1 from cycle 1, l2_address=0x1000, i_resp pulse in the same cycle as l2_resp, i_rdata=A, d_resp=0.
- D write-back: d_write=1, d_address=0x8000_0040, d_wdata=pattern B → l2_write=1, l2_wdata=B, l2_read=0, d_resp single pulse.
- Simultaneous i_read and d_read (fixed priority):
  - D served first, I served next after one IDLE cycle.
  - Addresses 0x2000 then 0x1000 appear on l2_address.
- Simultaneous requests, repeated twice, with L2_ARB_ROUND_ROBIN_EN: grants go D, I, then D, I. Without the macro, repeated back-to-back simultaneous requests from D always win.
- Reset asserted while in SERVE_D with l2_read=1 → l2_read=0 and state IDLE in the same cycle (asynchronous), no d_resp. After deassert, a fresh request is served normally.
- d_address changed during SERVE_D, before l2_resp → l2_address keeps the latched value.
